// File: rtl/seg7_scan.sv
// seg7_scan: four-digit common-anode seven-segment scanner.
//
// Shows a 16-bit hex value plus four decimal points, one digit per slot of
// PRESCALE cycles. The first BLANK cycles of every slot keep all anodes off
// so the previous digit's segments cannot ghost onto the next anode.
// Host writes go to a shadow register and are committed only at the end of
// a full four-digit scan, so a frame never mixes old and new data.
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous, active-high
//   wr_en      write strobe
//   wr_data    four hex nibbles, [3:0] = digit 0 ... [15:12] = digit 3
//   wr_dp      decimal points, bit i = digit i, 1 = lit
//   an         anode enables, active-low
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low
//   frame_done one-cycle pulse after each completed scan
module seg7_scan #(
  parameter int PRESCALE = 1024,
  parameter int BLANK    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    disp_dp_q, disp_dp_d;
  logic [15:0]   pend_q, pend_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          pend_valid_q, pend_valid_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;

  logic          slot_end;
  logic          frame_end;
  logic [3:0]    nibble;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == 2'd3);
    nibble    = disp_q[{idx_q, 2'b00} +: 4];

    cnt_d = slot_end ? '0 : cnt_q + CW'(1);
    idx_d = slot_end ? idx_q + 2'd1 : idx_q;

    // Commit uses the shadow value held before this edge; a write landing on
    // the same edge re-arms pend_valid and waits for the next frame.
    disp_d       = disp_q;
    disp_dp_d    = disp_dp_q;
    pend_valid_d = pend_valid_q;
    if (frame_end && pend_valid_q) begin
      disp_d       = pend_q;
      disp_dp_d    = pend_dp_q;
      pend_valid_d = 1'b0;
    end

    pend_d    = pend_q;
    pend_dp_d = pend_dp_q;
    if (wr_en) begin
      pend_d       = wr_data;
      pend_dp_d    = wr_dp;
      pend_valid_d = 1'b1;
    end

    frame_done_d = frame_end;

    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (cnt_q >= CNT_BLANK) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = hex_to_seg(nibble);
      dp_d  = ~disp_dp_q[idx_q];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      disp_q       <= 16'h0;
      disp_dp_q    <= 4'h0;
      pend_q       <= 16'h0;
      pend_dp_q    <= 4'h0;
      pend_valid_q <= 1'b0;
      an_q         <= 4'hF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan with PRESCALE=32, BLANK=4 (128-cycle frame).
module tb_seg7_scan;

  logic        clock;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  seg7_scan #(.PRESCALE(32), .BLANK(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // kind 0: optional write sampled at edge_n, then optional check after it.
  // kind 1: reset asserted on edge edge_n (0 = next edge); edge count restarts.
  typedef struct {
    int          kind;
    int          edge_n;
    logic        wen;
    logic [15:0] wd;
    logic [3:0]  wdp;
    logic        chk;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;
  } vec_t;

  vec_t vt[$];
  int   edge_cnt;
  int   n_vec;
  int   n_bad;

  function automatic vec_t mk(input int kind, input int edge_n, input logic wen,
                              input logic [15:0] wd, input logic [3:0] wdp,
                              input logic chk, input logic [3:0] e_an,
                              input logic [6:0] e_seg, input logic e_dp,
                              input logic e_fd);
    vec_t v;
    v.kind = kind; v.edge_n = edge_n; v.wen = wen; v.wd = wd; v.wdp = wdp;
    v.chk = chk; v.e_an = e_an; v.e_seg = e_seg; v.e_dp = e_dp; v.e_fd = e_fd;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    edge_cnt++;
  endtask

  task automatic check_out(input string name, input logic [3:0] e_an,
                           input logic [6:0] e_seg, input logic e_dp,
                           input logic e_fd);
    n_vec++;
    if (an !== e_an || seg !== e_seg || dp !== e_dp || frame_done !== e_fd) begin
      n_bad++;
      $display("FAIL %s: got an=%h seg=%h dp=%b fd=%b, want an=%h seg=%h dp=%b fd=%b",
               name, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
    end
  endtask

  initial begin
    int pulses;
    int bad_an;
    int bad_fd;

    reset    = 1'b1;
    wr_en    = 1'b0;
    wr_data  = 16'h0;
    wr_dp    = 4'h0;
    edge_cnt = 0;
    n_vec    = 0;
    n_bad    = 0;

    // Idle after reset
    vt.push_back(mk(1,   0, 0, 16'h0,    4'h0, 1, 4'hF, 7'h7F, 1, 0));
    vt.push_back(mk(0,   1, 0, 16'h0,    4'h0, 1, 4'hF, 7'h7F, 1, 0));
    vt.push_back(mk(0,   4, 0, 16'h0,    4'h0, 1, 4'hF, 7'h7F, 1, 0));
    vt.push_back(mk(0,   5, 0, 16'h0,    4'h0, 1, 4'hE, 7'h40, 1, 0));
    vt.push_back(mk(0,  37, 0, 16'h0,    4'h0, 1, 4'hD, 7'h40, 1, 0));
    // Single write mid-frame, committed at edge 128
    vt.push_back(mk(1,   0, 0, 16'h0,    4'h0, 1, 4'hF, 7'h7F, 1, 0));
    vt.push_back(mk(0,  10, 1, 16'h1234, 4'h1, 0, 4'h0, 7'h00, 0, 0));
    vt.push_back(mk(0, 101, 0, 16'h0,    4'h0, 1, 4'h7, 7'h40, 1, 0));
    vt.push_back(mk(0, 127, 0, 16'h0,    4'h0, 1, 4'h7, 7'h40, 1, 0));
    vt.push_back(mk(0, 128, 0, 16'h0,    4'h0, 1, 4'h7, 7'h40, 1, 1));
    vt.push_back(mk(0, 129, 0, 16'h0,    4'h0, 1, 4'hF, 7'h7F, 1, 0));
    vt.push_back(mk(0, 133, 0, 16'h0,    4'h0, 1, 4'hE, 7'h19, 0, 0));
    vt.push_back(mk(0, 165, 0, 16'h0,    4'h0, 1, 4'hD, 7'h30, 1, 0));
    vt.push_back(mk(0, 197, 0, 16'h0,    4'h0, 1, 4'hB, 7'h24, 1, 0));
    vt.push_back(mk(0, 229, 0, 16'h0,    4'h0, 1, 4'h7, 7'h79, 1, 0));
    // Two writes in one frame: last one wins
    vt.push_back(mk(1,   0, 0, 16'h0,    4'h0, 1, 4'hF, 7'h7F, 1, 0));
    vt.push_back(mk(0,  20, 1, 16'hAAAA, 4'hF, 0, 4'h0, 7'h00, 0, 0));
    vt.push_back(mk(0, 100, 1, 16'hC0DE, 4'hA, 0, 4'h0, 7'h00, 0, 0));
    vt.push_back(mk(0, 101, 0, 16'h0,    4'h0, 1, 4'h7, 7'h40, 1, 0));
    vt.push_back(mk(0, 133, 0, 16'h0,    4'h0, 1, 4'hE, 7'h06, 1, 0));
    vt.push_back(mk(0, 165, 0, 16'h0,    4'h0, 1, 4'hD, 7'h21, 0, 0));
    vt.push_back(mk(0, 197, 0, 16'h0,    4'h0, 1, 4'hB, 7'h40, 1, 0));
    vt.push_back(mk(0, 229, 0, 16'h0,    4'h0, 1, 4'h7, 7'h46, 0, 0));
    // Write exactly on the boundary edge waits one extra frame
    vt.push_back(mk(1,   0, 0, 16'h0,    4'h0, 1, 4'hF, 7'h7F, 1, 0));
    vt.push_back(mk(0, 128, 1, 16'hFFFF, 4'h0, 1, 4'h7, 7'h40, 1, 1));
    vt.push_back(mk(0, 133, 0, 16'h0,    4'h0, 1, 4'hE, 7'h40, 1, 0));
    vt.push_back(mk(0, 256, 0, 16'h0,    4'h0, 1, 4'h7, 7'h40, 1, 1));
    vt.push_back(mk(0, 261, 0, 16'h0,    4'h0, 1, 4'hE, 7'h0E, 1, 0));
    // Reset mid-scan while digit 2 is lit discards pending data
    vt.push_back(mk(1,   0, 0, 16'h0,    4'h0, 1, 4'hF, 7'h7F, 1, 0));
    vt.push_back(mk(0,  30, 1, 16'h5678, 4'hF, 0, 4'h0, 7'h00, 0, 0));
    vt.push_back(mk(0,  69, 0, 16'h0,    4'h0, 1, 4'hB, 7'h40, 1, 0));
    vt.push_back(mk(1,  70, 0, 16'h0,    4'h0, 1, 4'hF, 7'h7F, 1, 0));
    vt.push_back(mk(0,   1, 0, 16'h0,    4'h0, 1, 4'hF, 7'h7F, 1, 0));
    vt.push_back(mk(0,   5, 0, 16'h0,    4'h0, 1, 4'hE, 7'h40, 1, 0));
    vt.push_back(mk(0, 128, 0, 16'h0,    4'h0, 1, 4'h7, 7'h40, 1, 1));
    vt.push_back(mk(0, 133, 0, 16'h0,    4'h0, 1, 4'hE, 7'h40, 1, 0));
    // Reset landing on a boundary edge beats both commit and frame_done
    vt.push_back(mk(1,   0, 0, 16'h0,    4'h0, 1, 4'hF, 7'h7F, 1, 0));
    vt.push_back(mk(0,  40, 1, 16'h9999, 4'hF, 0, 4'h0, 7'h00, 0, 0));
    vt.push_back(mk(1, 128, 0, 16'h0,    4'h0, 1, 4'hF, 7'h7F, 1, 0));
    vt.push_back(mk(0,   5, 0, 16'h0,    4'h0, 1, 4'hE, 7'h40, 1, 0));

    for (int i = 0; i < vt.size(); i++) begin
      while (edge_cnt < vt[i].edge_n - 1) tick();
      if (vt[i].kind == 1) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        edge_cnt = 0;
      end else begin
        wr_en   = vt[i].wen;
        wr_data = vt[i].wd;
        wr_dp   = vt[i].wdp;
        tick();
        wr_en   = 1'b0;
      end
      if (vt[i].chk)
        check_out($sformatf("vec%0d", i), vt[i].e_an, vt[i].e_seg,
                  vt[i].e_dp, vt[i].e_fd);
    end

    // Three frames: at most one anode low, frame_done only on boundaries
    reset = 1'b1;
    tick();
    reset = 1'b0;
    edge_cnt = 0;
    wr_en   = 1'b1;
    wr_data = 16'h8421;
    wr_dp   = 4'h5;
    tick();
    wr_en = 1'b0;
    pulses = 0;
    bad_an = 0;
    bad_fd = 0;
    while (edge_cnt < 3 * 128 + 2) begin
      tick();
      if (an !== 4'hF && $countones(~an) != 1) bad_an++;
      if (frame_done === 1'b1) begin
        pulses++;
        if (edge_cnt % 128 != 0) bad_fd++;
      end else if (edge_cnt % 128 == 0) begin
        bad_fd++;
      end
    end
    n_vec++;
    if (bad_an != 0) begin
      n_bad++;
      $display("FAIL anode_onehot: got %0d bad cycles, want 0", bad_an);
    end
    n_vec++;
    if (pulses != 3) begin
      n_bad++;
      $display("FAIL frame_pulses: got %0d, want 3", pulses);
    end
    n_vec++;
    if (bad_fd != 0) begin
      n_bad++;
      $display("FAIL frame_timing: got %0d misplaced pulses, want 0", bad_fd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
